wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter between the MEM/WB pipeline register and the register files. The scalar and vector pipelines each present up to one scalar-RF write and one vector-RF write per cycle, but each register file has a single write port. The block merges the two streams onto the two ports with registered outputs. On a same-port collision it defers the vector pipeline's write through a one-entry buffer per port and stalls upstream for one cycle.

## Interface
Parameters:
- SAW, 5, scalar RF address width
- VAW, 5, vector RF address width
- SW, 36, scalar data width
- VW, 128, vector data width; lane mask is VW/32 = 4 bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_we, s_waddr, s_wdata  in  1/SAW/SW  scalar pipeline → scalar RF write
- s_vwe, s_vwaddr, s_vwdata, s_vmask  in  1/VAW/VW/4  scalar pipeline → vector RF write
- v_we, v_waddr, v_wdata  in  1/SAW/SW  vector pipeline → scalar RF write
- v_vwe, v_vwaddr, v_vwdata, v_vmask  in  1/VAW/VW/4  vector pipeline → vector RF write
- rf_we, rf_waddr, rf_wdata  out  1/SAW/SW  scalar RF write port
- vrf_we, vrf_waddr, vrf_wdata, vrf_mask  out  1/VAW/VW/4  vector RF write port
- stall  out  1  freezes MEM/WB (and everything upstream) this cycle
- conflict_cnt  out  16  collision count (only with WB_PERF_EN)

## Operation
- Two independent port lanes, scalar (S) and vector (V), with identical rules.
- Each lane holds a one-entry buffer {valid, addr, data[, mask]}.
- stall = sbuf_valid | vbuf_valid. It is a registered value, not combinational.
- When stall=1, all inputs are ignored. Upstream holds them and re-presents them the next cycle.
- Per-lane decision when stall=0:
  - Only the scalar-pipeline request asserted → output register loads it.
  - Only the vector-pipeline request asserted → output register loads it.
  - Both asserted (collision) → output loads the scalar-pipeline request, and the buffer captures the vector-pipeline request.
  - Neither asserted → output we=0.
- Collisions are resolved regardless of address. A same-address collision therefore leaves the vector-pipeline value as the final RF content.
- Per-lane decision when stall=1:
  - Buffer valid → output loads the buffer, and the buffer clears.
  - Buffer empty (only the other lane collided) → output we=0.
- When both lanes collide in the same cycle, both buffers fill and both drain in the same following cycle. stall stays high for exactly one cycle.
- Mask passes through unmodified. A mask of 0 with we=1 is still issued as a write.
- When output we=0, the addr/data/mask outputs hold their previous values. Verification must not check them.

## Timing
- Latency: 1 cycle from input to RF port (registered outputs).
- A collision in cycle N produces:
  - cycle N+1: scalar-pipeline write on the port, stall=1
  - cycle N+2: vector-pipeline write on the port, stall=0, new inputs accepted
- Back-to-back collisions are issued every other cycle. Maximum stall duty cycle is 50%.
- Reset (rst=0, asynchronous):
  - rf_we, vrf_we, stall, both buffer valid bits, conflict_cnt → 0
  - addr/data/mask outputs → 0
- Reset asserted mid-drain discards any buffered write. Dropping that write is the specified behaviour.
- Outputs become active on the first rising edge after rst deasserts.

## Configuration
- WB_PERF_EN defined:
  - conflict_cnt is present.
  - It increments by 1 in each accepted cycle where at least one lane collides. A dual-lane collision counts as 1.
  - It saturates at 16'hFFFF.
  - It resets to 0.
- WB_PERF_EN undefined: the conflict_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- No collision: s_we=1 addr 3 data 36'h1, v_vwe=1 addr 7 data all-ones mask 4'hF → next cycle rf_we=1 addr 3 data 1, vrf_we=1 addr 7 mask F, stall stays 0.
- Scalar-lane collision: s_we addr 2 data 36'hA and v_we addr 4 data 36'hB → N+1 rf writes reg 2 data A with stall=1 → N+2 rf writes reg 4 data B with stall=0; inputs driven during N+1 produce no write.
- Dual-lane collision, same address on each lane: stall is high for exactly one cycle, the vector-pipeline values land second on both ports, and conflict_cnt goes 0→1.
- Reset mid-drain: a collision followed by rst=0 in cycle N+1 → stall=0, rf_we=0 and vrf_we=0 immediately; after release, no buffered write appears.
- Continuous collisions for 10 cycles of accepted input → alternating stall pattern 1,0,1,…; 20 RF writes in order; conflict_cnt=10 (WB_PERF_EN). Saturation check: force the counter to FFFF, collide once, counter stays FFFF.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter between the MEM/WB pipeline register and the
//               scalar / vector register files. Two independent lanes (scalar
//               RF port, vector RF port) each merge the scalar-pipeline and the
//               vector-pipeline write requests onto a single registered write
//               port. On a same-lane collision the scalar-pipeline write goes
//               out first, the vector-pipeline write is parked in a one-entry
//               buffer and drained on the following cycle while stall freezes
//               the upstream pipeline.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk                                   clock, rising edge
//   rst                                   asynchronous, active-low reset
//   s_we/s_waddr/s_wdata                  scalar pipeline -> scalar RF write
//   s_vwe/s_vwaddr/s_vwdata/s_vmask       scalar pipeline -> vector RF write
//   v_we/v_waddr/v_wdata                  vector pipeline -> scalar RF write
//   v_vwe/v_vwaddr/v_vwdata/v_vmask       vector pipeline -> vector RF write
//   rf_we/rf_waddr/rf_wdata               scalar RF write port (registered)
//   vrf_we/vrf_waddr/vrf_wdata/vrf_mask   vector RF write port (registered)
//   stall                                 freezes MEM/WB and upstream
//   conflict_cnt                          saturating collision counter
//
// Configuration macro:
//   WB_PERF_EN  - when defined, adds the conflict_cnt port and its counter.
// ============================================================================
module wb_arbiter #(
    parameter int SAW = 5,
    parameter int VAW = 5,
    parameter int SW  = 36,
    parameter int VW  = 128
) (
    input  logic              clk,
    input  logic              rst,
    // scalar pipeline
    input  logic              s_we,
    input  logic [SAW-1:0]    s_waddr,
    input  logic [SW-1:0]     s_wdata,
    input  logic              s_vwe,
    input  logic [VAW-1:0]    s_vwaddr,
    input  logic [VW-1:0]     s_vwdata,
    input  logic [VW/32-1:0]  s_vmask,
    // vector pipeline
    input  logic              v_we,
    input  logic [SAW-1:0]    v_waddr,
    input  logic [SW-1:0]     v_wdata,
    input  logic              v_vwe,
    input  logic [VAW-1:0]    v_vwaddr,
    input  logic [VW-1:0]     v_vwdata,
    input  logic [VW/32-1:0]  v_vmask,
    // register file write ports
    output logic              rf_we,
    output logic [SAW-1:0]    rf_waddr,
    output logic [SW-1:0]     rf_wdata,
    output logic              vrf_we,
    output logic [VAW-1:0]    vrf_waddr,
    output logic [VW-1:0]     vrf_wdata,
    output logic [VW/32-1:0]  vrf_mask,
    output logic              stall
`ifdef WB_PERF_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int c_MW = VW / 32;

    // One-entry deferral buffers, one per lane
    logic              r_sbuf_valid;
    logic [SAW-1:0]    r_sbuf_addr;
    logic [SW-1:0]     r_sbuf_data;
    logic              r_vbuf_valid;
    logic [VAW-1:0]    r_vbuf_addr;
    logic [VW-1:0]     r_vbuf_data;
    logic [c_MW-1:0]   r_vbuf_mask;

    logic              w_accept;
    logic              w_s_coll;
    logic              w_v_coll;

    // A full buffer means a drain cycle is in progress; the buffers only ever
    // hold data for exactly one cycle, so this is the registered stall.
    assign stall    = r_sbuf_valid | r_vbuf_valid;
    assign w_accept = ~stall;
    assign w_s_coll = w_accept & s_we  & v_we;
    assign w_v_coll = w_accept & s_vwe & v_vwe;

    // ------------------------------------------------------------------
    // Scalar RF lane
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            r_sbuf_valid <= 1'b0;
            r_sbuf_addr  <= '0;
            r_sbuf_data  <= '0;
        end else if (w_accept) begin
            if (s_we) begin
                rf_we    <= 1'b1;
                rf_waddr <= s_waddr;
                rf_wdata <= s_wdata;
                if (v_we) begin
                    r_sbuf_valid <= 1'b1;
                    r_sbuf_addr  <= v_waddr;
                    r_sbuf_data  <= v_wdata;
                end
            end else if (v_we) begin
                rf_we    <= 1'b1;
                rf_waddr <= v_waddr;
                rf_wdata <= v_wdata;
            end else begin
                rf_we <= 1'b0;
            end
        end else begin
            // Drain cycle: inputs are ignored, only the buffer may issue
            if (r_sbuf_valid) begin
                rf_we        <= 1'b1;
                rf_waddr     <= r_sbuf_addr;
                rf_wdata     <= r_sbuf_data;
                r_sbuf_valid <= 1'b0;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector RF lane
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vrf_we       <= 1'b0;
            vrf_waddr    <= '0;
            vrf_wdata    <= '0;
            vrf_mask     <= '0;
            r_vbuf_valid <= 1'b0;
            r_vbuf_addr  <= '0;
            r_vbuf_data  <= '0;
            r_vbuf_mask  <= '0;
        end else if (w_accept) begin
            if (s_vwe) begin
                vrf_we    <= 1'b1;
                vrf_waddr <= s_vwaddr;
                vrf_wdata <= s_vwdata;
                vrf_mask  <= s_vmask;
                if (v_vwe) begin
                    r_vbuf_valid <= 1'b1;
                    r_vbuf_addr  <= v_vwaddr;
                    r_vbuf_data  <= v_vwdata;
                    r_vbuf_mask  <= v_vmask;
                end
            end else if (v_vwe) begin
                vrf_we    <= 1'b1;
                vrf_waddr <= v_vwaddr;
                vrf_wdata <= v_vwdata;
                vrf_mask  <= v_vmask;
            end else begin
                vrf_we <= 1'b0;
            end
        end else begin
            if (r_vbuf_valid) begin
                vrf_we       <= 1'b1;
                vrf_waddr    <= r_vbuf_addr;
                vrf_wdata    <= r_vbuf_data;
                vrf_mask     <= r_vbuf_mask;
                r_vbuf_valid <= 1'b0;
            end else begin
                vrf_we <= 1'b0;
            end
        end
    end

`ifdef WB_PERF_EN
    // ------------------------------------------------------------------
    // Collision counter: one count per accepted cycle with any collision,
    // saturating at all-ones.
    // ------------------------------------------------------------------
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conflict_cnt <= '0;
        end else if ((w_s_coll | w_v_coll) && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    // Collision flags only feed the optional counter
    logic w_unused;
    assign w_unused = w_s_coll | w_v_coll;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter. Inputs change
//               1 ns after the rising edge, outputs are checked at that same
//               point, away from the active edge. Counter checks are present
//               only when WB_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int SAW = 5;
    localparam int VAW = 5;
    localparam int SW  = 36;
    localparam int VW  = 128;
    localparam int MW  = VW / 32;

    logic             clk;
    logic             rst;
    logic             s_we,  v_we,  s_vwe, v_vwe;
    logic [SAW-1:0]   s_waddr, v_waddr;
    logic [SW-1:0]    s_wdata, v_wdata;
    logic [VAW-1:0]   s_vwaddr, v_vwaddr;
    logic [VW-1:0]    s_vwdata, v_vwdata;
    logic [MW-1:0]    s_vmask, v_vmask;
    logic             rf_we, vrf_we, stall;
    logic [SAW-1:0]   rf_waddr;
    logic [SW-1:0]    rf_wdata;
    logic [VAW-1:0]   vrf_waddr;
    logic [VW-1:0]    vrf_wdata;
    logic [MW-1:0]    vrf_mask;
`ifdef WB_PERF_EN
    logic [15:0]      conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.SAW(SAW), .VAW(VAW), .SW(SW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_we      (s_we),
        .s_waddr   (s_waddr),
        .s_wdata   (s_wdata),
        .s_vwe     (s_vwe),
        .s_vwaddr  (s_vwaddr),
        .s_vwdata  (s_vwdata),
        .s_vmask   (s_vmask),
        .v_we      (v_we),
        .v_waddr   (v_waddr),
        .v_wdata   (v_wdata),
        .v_vwe     (v_vwe),
        .v_vwaddr  (v_vwaddr),
        .v_vwdata  (v_vwdata),
        .v_vmask   (v_vmask),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .vrf_we    (vrf_we),
        .vrf_waddr (vrf_waddr),
        .vrf_wdata (vrf_wdata),
        .vrf_mask  (vrf_mask),
        .stall     (stall)
`ifdef WB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_we = 0; v_we = 0; s_vwe = 0; v_vwe = 0;
        s_waddr = '0; v_waddr = '0; s_wdata = '0; v_wdata = '0;
        s_vwaddr = '0; v_vwaddr = '0; s_vwdata = '0; v_vwdata = '0;
        s_vmask = '0; v_vmask = '0;
    endtask

    initial begin
        logic [VW-1:0] ones;
        logic [VW-1:0] vx;
        logic [VW-1:0] vy;
        ones = '1;
        vx   = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        vy   = {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};

        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b0;
        #2;
        chk("rst_rf_we",    128'(rf_we), 128'd0);
        chk("rst_vrf_we",   128'(vrf_we), 128'd0);
        chk("rst_stall",    128'(stall), 128'd0);
        chk("rst_rf_addr",  128'(rf_waddr), 128'd0);
        chk("rst_rf_data",  128'(rf_wdata), 128'd0);
        chk("rst_vrf_addr", 128'(vrf_waddr), 128'd0);
        chk("rst_vrf_data", 128'(vrf_wdata), 128'd0);
        chk("rst_vrf_mask", 128'(vrf_mask), 128'd0);
`ifdef WB_PERF_EN
        chk("rst_cnt",      128'(conflict_cnt), 128'd0);
`endif
        tick();
        rst = 1'b1;
        tick();
        chk("idle_rf_we",  128'(rf_we), 128'd0);
        chk("idle_vrf_we", 128'(vrf_we), 128'd0);

        // ---------------- no collision ----------------
        s_we = 1; s_waddr = 5'd3; s_wdata = 36'h1;
        v_vwe = 1; v_vwaddr = 5'd7; v_vwdata = ones; v_vmask = 4'hF;
        tick();
        chk("nc_rf_we",     128'(rf_we), 128'd1);
        chk("nc_rf_addr",   128'(rf_waddr), 128'd3);
        chk("nc_rf_data",   128'(rf_wdata), 128'h1);
        chk("nc_vrf_we",    128'(vrf_we), 128'd1);
        chk("nc_vrf_addr",  128'(vrf_waddr), 128'd7);
        chk("nc_vrf_data",  128'(vrf_wdata), 128'(ones));
        chk("nc_vrf_mask",  128'(vrf_mask), 128'hF);
        chk("nc_stall",     128'(stall), 128'd0);
        idle_inputs();
        tick();
        chk("nc_idle_rf_we",  128'(rf_we), 128'd0);
        chk("nc_idle_vrf_we", 128'(vrf_we), 128'd0);

        // ---------------- mask 0 still writes ----------------
        s_vwe = 1; s_vwaddr = 5'd9; s_vwdata = vx; s_vmask = 4'h0;
        tick();
        chk("m0_vrf_we",   128'(vrf_we), 128'd1);
        chk("m0_vrf_addr", 128'(vrf_waddr), 128'd9);
        chk("m0_vrf_mask", 128'(vrf_mask), 128'h0);
        chk("m0_stall",    128'(stall), 128'd0);
        idle_inputs();

        // ---------------- scalar-lane collision ----------------
        s_we = 1; s_waddr = 5'd2; s_wdata = 36'hA;
        v_we = 1; v_waddr = 5'd4; v_wdata = 36'hB;
        tick();                                   // N+1
        chk("sc1_rf_we",   128'(rf_we), 128'd1);
        chk("sc1_rf_addr", 128'(rf_waddr), 128'd2);
        chk("sc1_rf_data", 128'(rf_wdata), 128'hA);
        chk("sc1_stall",   128'(stall), 128'd1);
        chk("sc1_vrf_we",  128'(vrf_we), 128'd0);
        // Junk during the stall cycle must be ignored
        s_we = 1; s_waddr = 5'd9; s_wdata = 36'h55;
        v_we = 0;
        v_vwe = 1; v_vwaddr = 5'd10; v_vwdata = vy; v_vmask = 4'h5;
        tick();                                   // N+2
        chk("sc2_rf_we",   128'(rf_we), 128'd1);
        chk("sc2_rf_addr", 128'(rf_waddr), 128'd4);
        chk("sc2_rf_data", 128'(rf_wdata), 128'hB);
        chk("sc2_stall",   128'(stall), 128'd0);
        chk("sc2_vrf_we",  128'(vrf_we), 128'd0);
        idle_inputs();
        tick();
        chk("sc3_rf_we",   128'(rf_we), 128'd0);
        chk("sc3_vrf_we",  128'(vrf_we), 128'd0);
        chk("sc3_stall",   128'(stall), 128'd0);
`ifdef WB_PERF_EN
        chk("sc_cnt",      128'(conflict_cnt), 128'd1);
`endif

        // ---------------- dual-lane collision, same address per lane ----------------
        s_we = 1; s_waddr = 5'd5; s_wdata = 36'h1;
        v_we = 1; v_waddr = 5'd5; v_wdata = 36'h2;
        s_vwe = 1; s_vwaddr = 5'd6; s_vwdata = vx; s_vmask = 4'h3;
        v_vwe = 1; v_vwaddr = 5'd6; v_vwdata = vy; v_vmask = 4'hC;
        tick();
        chk("dl1_stall",    128'(stall), 128'd1);
        chk("dl1_rf_we",    128'(rf_we), 128'd1);
        chk("dl1_rf_data",  128'(rf_wdata), 128'h1);
        chk("dl1_vrf_we",   128'(vrf_we), 128'd1);
        chk("dl1_vrf_data", 128'(vrf_wdata), 128'(vx));
        chk("dl1_vrf_mask", 128'(vrf_mask), 128'h3);
`ifdef WB_PERF_EN
        chk("dl1_cnt",      128'(conflict_cnt), 128'd2);
`endif
        tick();                                   // upstream still holds inputs
        chk("dl2_stall",    128'(stall), 128'd0);
        chk("dl2_rf_we",    128'(rf_we), 128'd1);
        chk("dl2_rf_addr",  128'(rf_waddr), 128'd5);
        chk("dl2_rf_data",  128'(rf_wdata), 128'h2);
        chk("dl2_vrf_we",   128'(vrf_we), 128'd1);
        chk("dl2_vrf_addr", 128'(vrf_waddr), 128'd6);
        chk("dl2_vrf_data", 128'(vrf_wdata), 128'(vy));
        chk("dl2_vrf_mask", 128'(vrf_mask), 128'hC);
`ifdef WB_PERF_EN
        chk("dl2_cnt",      128'(conflict_cnt), 128'd2);
`endif
        idle_inputs();
        tick();
        chk("dl3_rf_we",  128'(rf_we), 128'd0);
        chk("dl3_vrf_we", 128'(vrf_we), 128'd0);

        // ---------------- reset mid-drain ----------------
        s_we = 1; s_waddr = 5'd1; s_wdata = 36'h11;
        v_we = 1; v_waddr = 5'd8; v_wdata = 36'h22;
        tick();
        chk("rd_pre_stall", 128'(stall), 128'd1);
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("rd_stall",  128'(stall), 128'd0);
        chk("rd_rf_we",  128'(rf_we), 128'd0);
        chk("rd_vrf_we", 128'(vrf_we), 128'd0);
`ifdef WB_PERF_EN
        chk("rd_cnt",    128'(conflict_cnt), 128'd0);
`endif
        tick();
        rst = 1'b1;
        tick();
        chk("rd_post_rf_we",  128'(rf_we), 128'd0);
        chk("rd_post_vrf_we", 128'(vrf_we), 128'd0);
        chk("rd_post_stall",  128'(stall), 128'd0);
        tick();
        chk("rd_post2_rf_we", 128'(rf_we), 128'd0);

        // ---------------- continuous collisions ----------------
        for (int k = 0; k < 10; k++) begin
            s_we = 1; s_waddr = 5'(k);      s_wdata = 36'(100 + 2 * k);
            v_we = 1; v_waddr = 5'(16 + k); v_wdata = 36'(101 + 2 * k);
            tick();
            chk("cc_a_stall", 128'(stall), 128'd1);
            chk("cc_a_we",    128'(rf_we), 128'd1);
            chk("cc_a_addr",  128'(rf_waddr), 128'(k));
            chk("cc_a_data",  128'(rf_wdata), 128'(100 + 2 * k));
            tick();
            chk("cc_b_stall", 128'(stall), 128'd0);
            chk("cc_b_we",    128'(rf_we), 128'd1);
            chk("cc_b_addr",  128'(rf_waddr), 128'(16 + k));
            chk("cc_b_data",  128'(rf_wdata), 128'(101 + 2 * k));
        end
        idle_inputs();
        tick();
        chk("cc_end_rf_we", 128'(rf_we), 128'd0);
        chk("cc_end_stall", 128'(stall), 128'd0);
`ifdef WB_PERF_EN
        chk("cc_cnt", 128'(conflict_cnt), 128'd10);

        // ---------------- counter saturation ----------------
        force dut.r_conflict_cnt = 16'hFFFF;
        #1;
        release dut.r_conflict_cnt;
        s_we = 1; s_waddr = 5'd2; s_wdata = 36'h3;
        v_we = 1; v_waddr = 5'd3; v_wdata = 36'h4;
        tick();
        idle_inputs();
        chk("sat_cnt1", 128'(conflict_cnt), 128'hFFFF);
        tick();
        chk("sat_cnt2", 128'(conflict_cnt), 128'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
